ax_rr_arbiter_mux: RTL and testbench
====================================

Name: ax_rr_arbiter_mux

Overview:
- Parametrised N-master to 1-slave AXI address-channel arbiter and multiplexer.
- Shared by the AW and AR paths of the interconnect.
- Round-robin arbitration; the grant is locked from selection until the AxVALID/AxREADY handshake completes.
- Returns AxREADY only to the granted master and prepends the master index to AxID so the response path can route B/R beats back.

Parameters:
NUM_MASTERS, 2, number of master ports (>=1)
ID_BITS, `AXI_ID_BITS, master-side ID width
ADDR_BITS, `AXI_ADDR_BITS, address width
LEN_BITS, `AXI_LEN_BITS, burst length width
SIZE_BITS, `AXI_SIZE_BITS, burst size width
MIDX_BITS, (NUM_MASTERS>1)?$clog2(NUM_MASTERS):1, master index width (derived, not overridden)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AxID_M  in  [NUM_MASTERS][ID_BITS]  per-master ID
AxADDR_M  in  [NUM_MASTERS][ADDR_BITS]  per-master address
AxLEN_M  in  [NUM_MASTERS][LEN_BITS]  per-master burst length
AxSIZE_M  in  [NUM_MASTERS][SIZE_BITS]  per-master burst size
AxBURST_M  in  [NUM_MASTERS][2]  per-master burst type
AxVALID_M  in  [NUM_MASTERS]  per-master valid
AxREADY_M  out  [NUM_MASTERS]  per-master ready
AxID_S  out  MIDX_BITS+ID_BITS  {master index, master ID}
AxADDR_S  out  ADDR_BITS  forwarded address
AxLEN_S  out  LEN_BITS  forwarded length
AxSIZE_S  out  SIZE_BITS  forwarded size
AxBURST_S  out  2  forwarded burst type
AxVALID_S  out  1  forwarded valid
AxREADY_S  in  1  slave ready
gnt_idx  out  MIDX_BITS  currently granted master index
gnt_busy  out  1  high while in GRANT state

Behaviour:
- Reset (ARESETn low, asynchronous): state=IDLE, gnt_idx=0, rr_ptr=0, AxVALID_S=0, AxREADY_M=all 0, gnt_busy=0. Payload outputs follow master gnt_idx=0 and are don't-care while AxVALID_S=0.
- State IDLE:
  - AxVALID_S=0; AxREADY_M=0.
  - If any AxVALID_M bit is set, pick the first set bit searching upward from rr_ptr, wrapping from NUM_MASTERS-1 to 0.
  - Register the winner into gnt_idx and go to GRANT on the next edge.
  - Arbitration latency is 1 cycle.
- State GRANT:
  - Payload = master[gnt_idx] fields, combinational from inputs.
  - AxID_S={gnt_idx, AxID_M[gnt_idx]}; AxVALID_S=AxVALID_M[gnt_idx].
  - AxREADY_M[gnt_idx]=AxREADY_S; all other AxREADY_M bits are 0.
  - gnt_busy=1.
- Handshake (AxVALID_S && AxREADY_S in GRANT): on that edge rr_ptr=(gnt_idx+1) mod NUM_MASTERS, state returns to IDLE.
  - Each transfer is therefore at least 2 cycles: 1 bubble cycle plus the handshake cycle.
- Grant lock: requests from other masters never pre-empt GRANT, and gnt_idx is stable throughout GRANT.
- Granted master drops AxVALID before handshake (protocol violation): return to IDLE next edge, rr_ptr unchanged, no transfer counted.
- Wrap: rr_ptr at NUM_MASTERS-1 wraps to 0. For non-power-of-2 NUM_MASTERS, rr_ptr and gnt_idx never exceed NUM_MASTERS-1.
- Simultaneous requests in IDLE: the lowest index at or above rr_ptr wins. Losers keep AxVALID asserted with AxREADY_M=0.
- NUM_MASTERS=1: gnt_idx is always 0 and the AxID_S index bit is 0. IDLE/GRANT sequencing still applies.
- Reset asserted mid-GRANT: outputs return to reset values immediately, asynchronously. The in-flight transfer is dropped.

Decomposition:
- Shared package axi_pkg: `AXI_* width macros or localparams, plus an ax_req_t struct {id, addr, len, size, burst}.
- Sub-module rr_arbiter (request vector, rr_ptr -> one-hot winner + index). It is reusable by the W/B/R routing blocks.

Test Plan:
- Reset, then M0 valid ADDR=0x1000 LEN=3 -> gnt_idx=0 after 1 cycle; AxVALID_S=1 with ADDR_S=0x1000 and AxID_S={0,ID}; AxREADY_M=2'b01 when AxREADY_S=1; back to IDLE.
- M0 and M1 both valid continuously, AxREADY_S=1 (NUM_MASTERS=2) -> grants alternate 0,1,0,1; one transfer every 2 cycles.
- NUM_MASTERS=3, all valid, rr_ptr=2 -> order 2,0,1,2.
- Grant lock: M1 granted, AxREADY_S held 0 for 5 cycles while M0 also requests -> gnt_idx stays 1, AxREADY_M[0]=0 throughout, payload stable.
- Granted M0 drops valid in GRANT -> IDLE next cycle, rr_ptr still 0; M0 reasserts and is granted again.
- ARESETn pulsed low mid-GRANT -> AxVALID_S=0 immediately; after release, state=IDLE and rr_ptr=0.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI widths, address-request struct and arbiter state type
package axi_pkg;

  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 8;
  localparam int AXI_SIZE_BITS = 3;

  typedef struct packed {
    logic [AXI_ID_BITS-1:0]   id;
    logic [AXI_ADDR_BITS-1:0] addr;
    logic [AXI_LEN_BITS-1:0]  len;
    logic [AXI_SIZE_BITS-1:0] size;
    logic [1:0]               burst;
  } ax_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } ax_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin winner search starting at a pointer, wrapping at N-1
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          found;

  // Walk candidates ptr, ptr+1, ... modulo N; the first requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/ax_rr_arbiter_mux.sv
// rtl/ax_rr_arbiter_mux.sv - N-to-1 AXI address-channel round-robin arbiter and mux
module ax_rr_arbiter_mux
  import axi_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ID_BITS     = AXI_ID_BITS,
  parameter int ADDR_BITS   = AXI_ADDR_BITS,
  parameter int LEN_BITS    = AXI_LEN_BITS,
  parameter int SIZE_BITS   = AXI_SIZE_BITS,
  localparam int MIDX_BITS  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [ID_BITS-1:0]           AxID_M    [NUM_MASTERS],
  input  logic [ADDR_BITS-1:0]         AxADDR_M  [NUM_MASTERS],
  input  logic [LEN_BITS-1:0]          AxLEN_M   [NUM_MASTERS],
  input  logic [SIZE_BITS-1:0]         AxSIZE_M  [NUM_MASTERS],
  input  logic [1:0]                   AxBURST_M [NUM_MASTERS],
  input  logic [NUM_MASTERS-1:0]       AxVALID_M,
  output logic [NUM_MASTERS-1:0]       AxREADY_M,
  output logic [MIDX_BITS+ID_BITS-1:0] AxID_S,
  output logic [ADDR_BITS-1:0]         AxADDR_S,
  output logic [LEN_BITS-1:0]          AxLEN_S,
  output logic [SIZE_BITS-1:0]         AxSIZE_S,
  output logic [1:0]                   AxBURST_S,
  output logic                         AxVALID_S,
  input  logic                         AxREADY_S,
  output logic [MIDX_BITS-1:0]         gnt_idx,
  output logic                         gnt_busy
);

  ax_arb_state_t        state, stateNext;
  logic [MIDX_BITS-1:0] gntIdx, gntIdxNext;
  logic [MIDX_BITS-1:0] rrPtr, rrPtrNext;
  logic [NUM_MASTERS-1:0] arbGnt;
  logic [MIDX_BITS-1:0] arbIdx;
  logic                 gntValid;

  rr_arbiter #(
    .N  (NUM_MASTERS),
    .IW (MIDX_BITS)
  ) u_rr_arbiter (
    .req (AxVALID_M),
    .ptr (rrPtr),
    .gnt (arbGnt),
    .idx (arbIdx)
  );

  assign gntValid = AxVALID_M[gntIdx];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state  <= IDLE;
      gntIdx <= '0;
      rrPtr  <= '0;
    end else begin
      state  <= stateNext;
      gntIdx <= gntIdxNext;
      rrPtr  <= rrPtrNext;
    end
  end

  // A granted master that withdraws valid releases the grant without advancing the pointer.
  always_comb begin
    stateNext  = state;
    gntIdxNext = gntIdx;
    rrPtrNext  = rrPtr;
    unique case (state)
      IDLE: begin
        if (|arbGnt) begin
          gntIdxNext = arbIdx;
          stateNext  = GRANT;
        end
      end
      GRANT: begin
        if (!gntValid) begin
          stateNext = IDLE;
        end else if (AxREADY_S) begin
          stateNext = IDLE;
          rrPtrNext = (gntIdx == MIDX_BITS'(NUM_MASTERS-1)) ? '0 : gntIdx + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    AxREADY_M = '0;
    if (state == GRANT) begin
      AxREADY_M[gntIdx] = AxREADY_S;
    end
  end

  assign AxVALID_S = (state == GRANT) && gntValid;
  assign AxID_S    = {gntIdx, AxID_M[gntIdx]};
  assign AxADDR_S  = AxADDR_M[gntIdx];
  assign AxLEN_S   = AxLEN_M[gntIdx];
  assign AxSIZE_S  = AxSIZE_M[gntIdx];
  assign AxBURST_S = AxBURST_M[gntIdx];
  assign gnt_idx   = gntIdx;
  assign gnt_busy  = (state == GRANT);

endmodule

// File: tb/tb_ax_rr_arbiter_mux.sv
// tb/tb_ax_rr_arbiter_mux.sv - directed bench for two- and three-master arbiter instances
module tb_ax_rr_arbiter_mux;

  logic ACLK;
  logic ARESETn;

  logic [3:0]  idM    [2];
  logic [31:0] addrM  [2];
  logic [7:0]  lenM   [2];
  logic [2:0]  sizeM  [2];
  logic [1:0]  burstM [2];
  logic [1:0]  validM;
  logic [1:0]  readyM;
  logic [4:0]  idS;
  logic [31:0] addrS;
  logic [7:0]  lenS;
  logic [2:0]  sizeS;
  logic [1:0]  burstS;
  logic        validS;
  logic        readyS;
  logic [0:0]  gntIdx;
  logic        gntBusy;

  logic [3:0]  idM3    [3];
  logic [31:0] addrM3  [3];
  logic [7:0]  lenM3   [3];
  logic [2:0]  sizeM3  [3];
  logic [1:0]  burstM3 [3];
  logic [2:0]  validM3;
  logic [2:0]  readyM3;
  logic [5:0]  idS3;
  logic [31:0] addrS3;
  logic [7:0]  lenS3;
  logic [2:0]  sizeS3;
  logic [1:0]  burstS3;
  logic        validS3;
  logic        readyS3;
  logic [1:0]  gntIdx3;
  logic        gntBusy3;

  int checks;
  int failures;

  ax_rr_arbiter_mux #(.NUM_MASTERS(2)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AxID_M(idM), .AxADDR_M(addrM), .AxLEN_M(lenM), .AxSIZE_M(sizeM), .AxBURST_M(burstM),
    .AxVALID_M(validM), .AxREADY_M(readyM),
    .AxID_S(idS), .AxADDR_S(addrS), .AxLEN_S(lenS), .AxSIZE_S(sizeS), .AxBURST_S(burstS),
    .AxVALID_S(validS), .AxREADY_S(readyS),
    .gnt_idx(gntIdx), .gnt_busy(gntBusy)
  );

  ax_rr_arbiter_mux #(.NUM_MASTERS(3)) dut3 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AxID_M(idM3), .AxADDR_M(addrM3), .AxLEN_M(lenM3), .AxSIZE_M(sizeM3), .AxBURST_M(burstM3),
    .AxVALID_M(validM3), .AxREADY_M(readyM3),
    .AxID_S(idS3), .AxADDR_S(addrS3), .AxLEN_S(lenS3), .AxSIZE_S(sizeS3), .AxBURST_S(burstS3),
    .AxVALID_S(validS3), .AxREADY_S(readyS3),
    .gnt_idx(gntIdx3), .gnt_busy(gntBusy3)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic apply_reset();
    ARESETn = 1'b0;
    validM  = '0;
    readyS  = 1'b0;
    validM3 = '0;
    readyS3 = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    validM  = 2'b11;
    readyS  = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    checks++; if (validS !== 1'b0) begin failures++; $display("FAIL reset_valid_s: got %b expected 0", validS); end
    checks++; if (readyM !== 2'b00) begin failures++; $display("FAIL reset_ready_m: got %b expected 00", readyM); end
    checks++; if (gntBusy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", gntBusy); end
    checks++; if (gntIdx !== 1'b0) begin failures++; $display("FAIL reset_gnt_idx: got %0d expected 0", gntIdx); end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    idM[0] = 4'h5; addrM[0] = 32'h1000; lenM[0] = 8'd3; sizeM[0] = 3'd2; burstM[0] = 2'b01;
    validM = 2'b01;
    checks++; if (validS !== 1'b0) begin failures++; $display("FAIL single_idle_valid: got %b expected 0", validS); end
    tick();
    checks++; if (gntIdx !== 1'b0 || gntBusy !== 1'b1) begin failures++; $display("FAIL single_grant: got idx=%0d busy=%b expected idx=0 busy=1", gntIdx, gntBusy); end
    checks++; if (validS !== 1'b1) begin failures++; $display("FAIL single_valid_s: got %b expected 1", validS); end
    checks++; if (addrS !== 32'h1000 || lenS !== 8'd3) begin failures++; $display("FAIL single_payload: got addr=%h len=%0d expected 1000/3", addrS, lenS); end
    checks++; if (sizeS !== 3'd2 || burstS !== 2'b01) begin failures++; $display("FAIL single_size_burst: got %0d/%b expected 2/01", sizeS, burstS); end
    checks++; if (idS !== 5'h05) begin failures++; $display("FAIL single_id_s: got %h expected 05", idS); end
    checks++; if (readyM !== 2'b00) begin failures++; $display("FAIL single_ready_low: got %b expected 00", readyM); end
    readyS = 1'b1;
    #1;
    checks++; if (readyM !== 2'b01) begin failures++; $display("FAIL single_ready_m: got %b expected 01", readyM); end
    tick();
    validM = 2'b00;
    readyS = 1'b0;
    checks++; if (gntBusy !== 1'b0) begin failures++; $display("FAIL single_back_idle: got busy=%b expected 0", gntBusy); end
  endtask

  task automatic test_alternate();
    logic [0:0] exp;
    apply_reset();
    idM[0] = 4'hA; addrM[0] = 32'h0000_0100;
    idM[1] = 4'h3; addrM[1] = 32'h0000_0200;
    validM = 2'b11;
    readyS = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 1) ? 1'b1 : 1'b0;
      tick();
      checks++; if (gntIdx !== exp || gntBusy !== 1'b1) begin failures++; $display("FAIL alt_grant_%0d: got idx=%0d busy=%b expected idx=%0d busy=1", i, gntIdx, gntBusy, exp); end
      checks++; if (readyM !== (exp ? 2'b10 : 2'b01)) begin failures++; $display("FAIL alt_ready_%0d: got %b expected one-hot %0d", i, readyM, exp); end
      checks++; if (idS !== (exp ? 5'h13 : 5'h0A)) begin failures++; $display("FAIL alt_id_%0d: got %h expected %h", i, idS, exp ? 5'h13 : 5'h0A); end
      tick();
      checks++; if (gntBusy !== 1'b0 || validS !== 1'b0) begin failures++; $display("FAIL alt_bubble_%0d: got busy=%b valid=%b expected 0/0", i, gntBusy, validS); end
    end
    validM = 2'b00;
    readyS = 1'b0;
  endtask

  task automatic test_three_masters();
    int seq [4] = '{2, 0, 1, 2};
    apply_reset();
    for (int m = 0; m < 3; m++) begin
      idM3[m] = 4'(m + 4); addrM3[m] = 32'h3000 + 32'(m * 16);
      lenM3[m] = 8'(m); sizeM3[m] = 3'd0; burstM3[m] = 2'b01;
    end
    validM3 = 3'b010;
    readyS3 = 1'b1;
    tick();
    tick();
    validM3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (gntIdx3 !== 2'(seq[i])) begin failures++; $display("FAIL rr3_grant_%0d: got %0d expected %0d", i, gntIdx3, seq[i]); end
      checks++; if (readyM3 !== 3'(1 << seq[i]) || addrS3 !== 32'h3000 + 32'(seq[i] * 16)) begin failures++; $display("FAIL rr3_route_%0d: got ready=%b addr=%h expected master %0d", i, readyM3, addrS3, seq[i]); end
      checks++; if (idS3 !== {2'(seq[i]), 4'(seq[i] + 4)}) begin failures++; $display("FAIL rr3_id_%0d: got %h", i, idS3); end
      tick();
    end
    validM3 = '0;
    readyS3 = 1'b0;
  endtask

  task automatic test_grant_lock();
    apply_reset();
    addrM[0] = 32'h2000; addrM[1] = 32'h2100;
    idM[1] = 4'h7;
    validM = 2'b10;
    readyS = 1'b0;
    tick();
    validM = 2'b11;
    for (int i = 0; i < 5; i++) begin
      checks++; if (gntIdx !== 1'b1 || readyM !== 2'b00 || addrS !== 32'h2100 || validS !== 1'b1) begin failures++; $display("FAIL lock_cycle_%0d: got idx=%0d ready=%b addr=%h valid=%b expected 1/00/2100/1", i, gntIdx, readyM, addrS, validS); end
      tick();
    end
    readyS = 1'b1;
    #1;
    checks++; if (readyM !== 2'b10) begin failures++; $display("FAIL lock_release_ready: got %b expected 10", readyM); end
    tick();
    tick();
    checks++; if (gntIdx !== 1'b0 || gntBusy !== 1'b1) begin failures++; $display("FAIL lock_wrap_next: got idx=%0d busy=%b expected 0/1", gntIdx, gntBusy); end
    validM = 2'b00;
    readyS = 1'b0;
  endtask

  task automatic test_drop_valid();
    apply_reset();
    validM = 2'b01;
    readyS = 1'b0;
    tick();
    validM = 2'b00;
    #1;
    checks++; if (validS !== 1'b0) begin failures++; $display("FAIL drop_valid_s: got %b expected 0", validS); end
    tick();
    checks++; if (gntBusy !== 1'b0) begin failures++; $display("FAIL drop_idle: got busy=%b expected 0", gntBusy); end
    validM = 2'b11;
    tick();
    checks++; if (gntIdx !== 1'b0 || gntBusy !== 1'b1) begin failures++; $display("FAIL drop_regrant: got idx=%0d busy=%b expected 0/1", gntIdx, gntBusy); end
    validM = 2'b00;
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    validM = 2'b01;
    readyS = 1'b1;
    tick();
    tick();
    validM = 2'b10;
    readyS = 1'b0;
    tick();
    checks++; if (gntIdx !== 1'b1 || validS !== 1'b1) begin failures++; $display("FAIL rst_pre_grant: got idx=%0d valid=%b expected 1/1", gntIdx, validS); end
    #2;
    ARESETn = 1'b0;
    #1;
    checks++; if (validS !== 1'b0 || gntBusy !== 1'b0 || gntIdx !== 1'b0) begin failures++; $display("FAIL rst_async: got valid=%b busy=%b idx=%0d expected 0/0/0", validS, gntBusy, gntIdx); end
    tick();
    ARESETn = 1'b1;
    validM = 2'b11;
    readyS = 1'b1;
    checks++; if (gntBusy !== 1'b0) begin failures++; $display("FAIL rst_idle: got busy=%b expected 0", gntBusy); end
    tick();
    checks++; if (gntIdx !== 1'b0) begin failures++; $display("FAIL rst_ptr_zero: got idx=%0d expected 0", gntIdx); end
    validM = 2'b00;
    readyS = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ARESETn  = 1'b0;
    validM   = '0;
    readyS   = 1'b0;
    validM3  = '0;
    readyS3  = 1'b0;
    for (int m = 0; m < 2; m++) begin
      idM[m] = '0; addrM[m] = '0; lenM[m] = '0; sizeM[m] = '0; burstM[m] = '0;
    end
    for (int m = 0; m < 3; m++) begin
      idM3[m] = '0; addrM3[m] = '0; lenM3[m] = '0; sizeM3[m] = '0; burstM3[m] = '0;
    end
    test_reset();
    test_single();
    test_alternate();
    test_three_masters();
    test_grant_lock();
    test_drop_valid();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
